// File: rtl/vo_timing_gen.sv
// vo_timing_gen: output video timing generator; requests frame-buffer pixels and emits aligned hs/vs/de/rgb.
// Latency: vo_de/vo_vs one cycle after the counters; hs/vs/de/rgb RD_LATENCY+1 cycles after vo_de/vo_vs/hsync.
// Backpressure: none, runs at the pixel rate; a pixel that misses its slot is blue-filled and flagged sticky.
// Optional feature: define VO_TPG_EN to add the tpg_sel colour-bar generator.
module vo_timing_gen #(
  parameter int H_DISP     = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_DISP     = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter int RD_LATENCY = 2
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        vo_vs,
  output logic        vo_de,
  input  logic [15:0] video_data,
  input  logic        video_de,
  input  logic        tpg_sel,
  input  logic        underflow_clr,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [23:0] rgb,
  output logic        underflow
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_E  = 12'(H_DISP);
  localparam logic [11:0] H_SYNC_S = 12'(H_DISP + H_FP);
  localparam logic [11:0] H_SYNC_E = 12'(H_DISP + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_E  = 12'(V_DISP);
  localparam logic [11:0] V_SYNC_S = 12'(V_DISP + V_FP);
  localparam logic [11:0] V_SYNC_E = 12'(V_DISP + V_FP + V_SYNC);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      state_q, state_d;
  logic        running;
  logic [11:0] h_cnt, v_cnt;
  logic        h_last, v_last, frame_end;
  logic        h_act, h_sync, v_act, v_sync;
  logic        hsync_q;
  logic [2:0]  dly [RD_LATENCY];
  logic        tap_hs, tap_vs, tap_de;
  logic [23:0] px_rgb;
  logic [23:0] bar_rgb;
  logic        use_bars;
  logic        miss;

  assign running   = (state_q == ST_RUN);
  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign frame_end = h_last && v_last;

  // Run-control state register
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Start as soon as en is seen while idle; once running, stop only on the last pixel of a frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (!en && frame_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel/line counters; parked at 0,0 while idle so a restart always begins at frame start
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
      if (h_last) v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
    end
  end

  assign h_act  = (h_cnt < H_ACT_E);
  assign h_sync = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
  assign v_act  = (v_cnt < V_ACT_E);
  assign v_sync = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);

  // Registered region decodes; gated by running so nothing is requested while idle
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      vo_de   <= 1'b0;
      vo_vs   <= 1'b0;
      hsync_q <= 1'b0;
    end else begin
      vo_de   <= running && h_act && v_act;
      vo_vs   <= running && v_sync;
      hsync_q <= running && h_sync;
    end
  end

  // Delay the timing strobes by the frame-buffer read latency so they line up with video_data
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {hsync_q, vo_vs, vo_de};
      for (int i = 1; i < RD_LATENCY; i++) dly[i] <= dly[i-1];
    end
  end

  assign tap_hs = dly[RD_LATENCY-1][2];
  assign tap_vs = dly[RD_LATENCY-1][1];
  assign tap_de = dly[RD_LATENCY-1][0];

  // RGB565 to RGB888 by replicating the top bits into the low bits
  assign px_rgb = {video_data[15:11], video_data[15:13],
                   video_data[10:5],  video_data[10:9],
                   video_data[4:0],   video_data[4:2]};

`ifdef VO_TPG_EN
  localparam int          BAR_W    = H_DISP / 8;
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

  logic        tpg_act;
  logic [11:0] bar_px;
  logic [2:0]  bar_idx;

  // Bar select is taken once per frame so a frame never mixes pixel sources
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n)                                      tpg_act <= 1'b0;
    else if (running && h_cnt == '0 && v_cnt == '0) tpg_act <= tpg_sel;
  end

  // Aligned column position, split into pixel-within-bar and bar index
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (!tap_de) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px  <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px  <= bar_px + 12'd1;
    end
  end

  // Bar order white,yellow,cyan,green,magenta,red,blue,black: R on when idx[1]=0, G when idx[2]=0, B when idx[0]=0
  assign bar_rgb  = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
  assign use_bars = tpg_act;
`else
  logic unused_tpg_sel;
  assign unused_tpg_sel = tpg_sel;
  assign bar_rgb        = '0;
  assign use_bars       = 1'b0;
`endif

  // A pixel slot with no data is only a fault when frame-buffer data is actually being shown
  assign miss = tap_de && !video_de && !use_bars;

  // Output stage: aligned strobes, pixel selection and the sticky underflow flag (set beats clear)
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs        <= 1'b0;
      vs        <= 1'b0;
      de        <= 1'b0;
      rgb       <= '0;
      underflow <= 1'b0;
    end else begin
      hs <= tap_hs;
      vs <= tap_vs;
      de <= tap_de;
      if (!tap_de)      rgb <= '0;
      else if (use_bars) rgb <= bar_rgb;
      else if (miss)     rgb <= 24'h0000FF;
      else               rgb <= px_rgb;
      if (miss)               underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vo_timing_gen.sv
// tb_vo_timing_gen: frame-buffer model plus rgb scoreboard for vo_timing_gen with a small 22x7 raster.
// Expected pixels are queued when the model returns data and popped when the DUT raises de.
// Timing, lag, underflow and idle behaviour are checked against bench-side history and constants.
module tb_vo_timing_gen;

  localparam int MISS_A = 90;
  localparam int MISS_B = 140;
  localparam int MISS_C = 150;
  localparam int CLR_A  = 120;
  localparam int CLR_C  = 180;

  logic        video_clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        vo_vs, vo_de;
  logic [15:0] video_data;
  logic        video_de;
  logic        tpg_sel;
  logic        underflow_clr;
  logic        hs, vs, de;
  logic [23:0] rgb;
  logic        underflow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [23:0] exp_q [$];
  logic req_d0, req_d1;
  logic h_de0, h_de1, h_de2, h_vs0, h_vs1, h_vs2;
  logic uf_model;
  logic prev_vo_de, prev_de;
  bit   frame_rise;
  bit   rand_mode, withhold_all, tpg_on;
  int   pix_idx = 0;
  int   line_px, since_de, de_run;

  always #5 video_clk = ~video_clk;

  vo_timing_gen #(
    .H_DISP(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISP(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
    .RD_LATENCY(2)
  ) dut (
    .video_clk    (video_clk),
    .rst_n        (rst_n),
    .en           (en),
    .vo_vs        (vo_vs),
    .vo_de        (vo_de),
    .video_data   (video_data),
    .video_de     (video_de),
    .tpg_sel      (tpg_sel),
    .underflow_clr(underflow_clr),
    .hs           (hs),
    .vs           (vs),
    .de           (de),
    .rgb          (rgb),
    .underflow    (underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] expand565(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_clear();
    exp_q.delete();
    req_d0 = 0; req_d1 = 0;
    h_de0 = 0; h_de1 = 0; h_de2 = 0;
    h_vs0 = 0; h_vs1 = 0; h_vs2 = 0;
    uf_model = 0; prev_vo_de = 0; prev_de = 0; frame_rise = 0;
    line_px = 0; since_de = 100; de_run = 0;
    video_de = 0; video_data = '0; underflow_clr = 0;
  endtask

  // One clock: check outputs against history/scoreboard, then drive the frame-buffer model
  task automatic step();
    logic        drv, miss;
    logic [15:0] d;
    logic [23:0] e;
    @(posedge video_clk);
    #1;
    cyc++;
    check("de_lag", 32'(de), 32'(h_de2));
    check("vs_lag", 32'(vs), 32'(h_vs2));
    check("underflow", 32'(underflow), 32'(uf_model));
    if (de) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rgb", 32'(rgb), 32'(e));
      end
      de_run++;
    end else begin
      if (prev_de) check("de_run", 32'(de_run), 16);
      de_run = 0;
    end
    prev_de = de;
    h_de2 = h_de1; h_de1 = h_de0; h_de0 = vo_de;
    h_vs2 = h_vs1; h_vs1 = h_vs0; h_vs0 = vo_vs;
    frame_rise = vo_de && !prev_vo_de && (since_de > 10);
    since_de   = vo_de ? 0 : since_de + 1;
    prev_vo_de = vo_de;

    drv = req_d1; req_d1 = req_d0; req_d0 = vo_de;
    video_de = 0; underflow_clr = 0; video_data = '0;
    if (drv) begin
      d    = rand_mode ? 16'($urandom) : 16'hF800;
      miss = withhold_all || pix_idx == MISS_A || pix_idx == MISS_B || pix_idx == MISS_C;
      video_data    = d;
      video_de      = !miss;
      underflow_clr = (pix_idx == CLR_A) || (pix_idx == MISS_C) || (pix_idx == CLR_C);
      if (tpg_on)    e = bar_colour(line_px / 2);
      else if (miss) e = 24'h0000FF;
      else           e = expand565(d);
      exp_q.push_back(e);
      if (miss && !tpg_on)    uf_model = 1;
      else if (underflow_clr) uf_model = 0;
      pix_idx++;
      line_px++;
    end else begin
      line_px = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_vde, n_vvs, n_hs, n_vs, n_de;
    bit found;
    rst_n = 0; en = 0; tpg_sel = 0;
    rand_mode = 0; withhold_all = 0; tpg_on = 0;
    model_clear();
    repeat (3) step();
    check("rst_vo_de", 32'(vo_de), 0);
    check("rst_vo_vs", 32'(vo_vs), 0);
    check("rst_hs", 32'(hs), 0);
    check("rst_vs", 32'(vs), 0);
    check("rst_de", 32'(de), 0);
    check("rst_rgb", 32'(rgb), 0);
    check("rst_underflow", 32'(underflow), 0);
    rst_n = 1;
    step(); step();

    // First frame: constant red pixels, request timing and per-frame counts
    en = 1;
    step();
    check("start_c1_vo_de", 32'(vo_de), 0);
    step();
    check("start_rise_vo_de", 32'(vo_de), 1);
    n_vde = 0; n_vvs = 0; n_de = 0;
    for (int i = 0; i < 154; i++) begin
      n_vde += int'(vo_de); n_vvs += int'(vo_vs); n_de += int'(de);
      step();
    end
    check("f1_vo_de_cnt", 32'(n_vde), 64);
    check("f1_vo_vs_cnt", 32'(n_vvs), 22);
    check("f1_de_cnt", 32'(n_de), 64);

    // Random pixels with misses and clears; tpg_sel must be ignored without the bar feature
    rand_mode = 1;
`ifndef VO_TPG_EN
    tpg_sel = 1;
`endif
    repeat (308) step();
    tpg_sel = 0;

    // Drop en on line 1 of a frame: the frame completes, then everything goes quiet
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (frame_rise) found = 1;
    end
    check("find_frame_start", 32'(found), 1);
    n_vde = 0; n_vvs = 0; n_hs = 0; n_vs = 0; n_de = 0;
    for (int i = 0; i < 154; i++) begin
      n_vde += int'(vo_de); n_vvs += int'(vo_vs); n_hs += int'(hs);
      n_vs += int'(vs); n_de += int'(de);
      if (i == 22) en = 0;
      step();
    end
    check("stop_vo_de_cnt", 32'(n_vde), 64);
    check("stop_vo_vs_cnt", 32'(n_vvs), 22);
    check("stop_hs_cnt", 32'(n_hs), 14);
    check("stop_vs_cnt", 32'(n_vs), 22);
    check("stop_de_cnt", 32'(n_de), 64);
    repeat (10) step();
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_outputs", 32'({vo_de, vo_vs, hs, vs, de, rgb}), 0);
    end

    // Restart, then reset mid-line
    en = 1;
    step(); step();
    check("restart_rise", 32'(vo_de), 1);
    repeat (5) step();
    check("midline_vo_de", 32'(vo_de), 1);
    rst_n = 0; en = 0;
    model_clear();
    step();
    check("rst_mid_outputs", 32'({vo_de, vo_vs, hs, vs, de, rgb, underflow}), 0);
    rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      check("no_de_after_rst", 32'({vo_de, de}), 0);
    end
    en = 1;
    step();
    check("rst_restart_c1", 32'(vo_de), 0);
    step();
    check("rst_restart_rise", 32'(vo_de), 1);
    repeat (160) step();

`ifdef VO_TPG_EN
    // Colour bars with no frame-buffer data at all: bars shown, no underflow
    rst_n = 0; en = 0;
    model_clear();
    step();
    rst_n = 1;
    step();
    tpg_sel = 1; tpg_on = 1; withhold_all = 1; en = 1;
    repeat (160) step();
`endif

    en = 0;
    repeat (340) step();
    check("sb_drain", 32'(exp_q.size()), 0);
    check("final_idle", 32'({vo_de, vo_vs, de}), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vo_timing_gen.md
# vo_timing_gen

Output-side video timing generator in the `video_clk` domain. It sits between the frame-buffer read path and the HDMI encoder:
- drives the `vo_vs`/`vo_de` read requests toward the frame buffer;
- captures the returned RGB565 pixels after a fixed read latency;
- emits latency-aligned `hs`/`vs`/`de` with 24-bit RGB to the TMDS encoder;
- flags pixels that did not arrive on time.

## Interface
- `H_DISP`, 1280: active pixels per line; must be a multiple of 8.
- `H_FP`, 110: horizontal front porch, in pixels.
- `H_SYNC`, 40: hsync width, in pixels.
- `H_BP`, 220: horizontal back porch, in pixels.
- `V_DISP`, 720: active lines per frame.
- `V_FP`, 5: vertical front porch, in lines.
- `V_SYNC`, 5: vsync width, in lines.
- `V_BP`, 20: vertical back porch, in lines.
- `RD_LATENCY`, 2: cycles from `vo_de` high to the matching `video_data` being valid; range 1..8.

Ports:
- `video_clk` in 1: pixel clock, the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: run request.
- `vo_vs` out 1: vsync-region request to the frame buffer.
- `vo_de` out 1: pixel read request.
- `video_data` in 16: RGB565 pixel from the frame buffer.
- `video_de` in 1: `video_data` valid.
- `tpg_sel` in 1: select colour bars (only used with the macro).
- `underflow_clr` in 1: clear the sticky underflow flag.
- `hs` out 1: aligned hsync, active high.
- `vs` out 1: aligned vsync, active high.
- `de` out 1: aligned data enable.
- `rgb` out 24: {R8,G8,B8} pixel data.
- `underflow` out 1: sticky flag, a pixel was missing.

## Operation
- Totals: `H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP`, `V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP`.
- Counters: `h_cnt` counts 0..H_TOTAL-1; `v_cnt` counts 0..V_TOTAL-1.
  - `v_cnt` increments when `h_cnt` wraps.
  - Both wrap to 0; both are 12 bits wide.
- Line layout by `h_cnt`: [0,H_DISP) active, then front porch, then sync, then back porch.
- Frame layout by `v_cnt`: same order, in lines.
- Decode:
  - `vo_de` = h active AND v active.
  - `vo_vs` = v sync region.
  - hsync = h sync region.
- Run control (flag `running`):
  - `running` is 0 at reset.
  - Idle with `en`=1: set `running`; counters start from 0,0 on the next cycle.
  - Running with `en`=0: `running` clears only at frame end (h=H_TOTAL-1, v=V_TOTAL-1).
  - While idle, counters hold 0 and every request/output is 0.
- Alignment:
  - `{hsync, vo_vs, vo_de}` passes through an RD_LATENCY-deep shift register.
  - The tap is registered once more with `rgb` to form `hs`/`vs`/`de`.
- RGB expansion: `{R5,R5[4:2]}`, `{G6,G6[5:4]}`, `{B5,B5[4:2]}`.
- Underflow:
  - Trigger: aligned de=1 with `video_de`=0.
  - `rgb` becomes 0x0000FF (blue fill) for that pixel, and `underflow` sets.
  - `underflow_clr` clears it. If set and clear happen in the same cycle, set wins.
  - `video_de`=1 while aligned de=0 is ignored.

## Timing
- Reset values: `vo_vs`, `vo_de`, `hs`, `vs`, `de`, `underflow` = 0; `rgb` = 0.
- Request timing: `vo_de`/`vo_vs` are registered decodes, one cycle after the counter value they reflect.
- First `vo_de` rises 2 cycles after the cycle in which `en` is sampled high while idle.
- Output latency: `de`/`hs`/`vs`/`rgb` lag `vo_de`/`vo_vs`/hsync by exactly RD_LATENCY+1 cycles.
- Each line has exactly H_DISP `de` cycles. Each frame has exactly V_DISP `de` lines.
- Reset asserted mid-frame: all state clears immediately. After release, the block waits for `en`.
- `en` dropped mid-frame: the frame completes in full, and the shift register drains naturally.

## Configuration
- Macro: `VO_TPG_EN`.
- Defined: `tpg_sel`=1 replaces pixel data with 8 vertical colour bars, each H_DISP/8 wide.
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Bar position comes from an aligned column counter, reset when aligned de is low.
  - Underflow detection is suppressed while bars are selected.
  - `tpg_sel` is sampled at frame start only.
- Undefined: `tpg_sel` is ignored and no bar logic is synthesized.

## Test plan
All scenarios use small parameters: H 16/2/2/2 (H_TOTAL 22), V 4/1/1/1 (V_TOTAL 7), RD_LATENCY=2.
- Reset, then `en`=1 → `vo_de` rises 2 cycles later. It runs 16 cycles high / 6 low, 4 lines per 154-cycle frame, and `vo_vs` is high for 22 cycles per frame.
- Frame buffer model returns `video_data`=0xF800 with `video_de` exactly 2 cycles after `vo_de` → `de` lags `vo_de` by 3 cycles, `rgb`=0xFF0000, `underflow` stays 0.
- `video_de` withheld for one pixel → that pixel's `rgb`=0x0000FF and `underflow`=1 until `underflow_clr`. Assert `underflow_clr` and a new miss in the same cycle → flag stays 1.
- `en` dropped at line 1 of a frame → the frame completes (154 cycles from its start), then all outputs stay 0.
- `rst_n` pulsed mid-line → outputs are 0 on the next edge and no `de` appears until `en` is re-sampled.
- `VO_TPG_EN` defined with `tpg_sel`=1 → each `de` line shows 2 pixels of each bar colour in order FFFFFF…000000, and `underflow` stays 0 with `video_de`=0.
